// File: rtl/rv32im_dmem_ctrl_if.sv
// rv32im_dmem_ctrl_if: request/grant/response data-bus bundle between the controller and memory.
interface rv32im_dmem_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  modport master(output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/rv32im_dmem_ctrl.sv
// rv32im_dmem_ctrl: data-memory access controller with stall, misalign detection and bus timeout.
module rv32im_dmem_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  misalign_o,
  output logic                  err_o,
  rv32im_dmem_ctrl_if.master    bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic                  we_q, mis_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q;
  logic                  misalign, busy, complete, tmo;
  assign misalign = (size_i == 2'd1 && addr_i[0]) || (size_i[1] && addr_i[1:0] != 2'b00);
  assign be_d     = size_i == 2'd0 ? 4'b0001 << addr_i[1:0] : size_i == 2'd1 ? 4'b0011 << addr_i[1:0] : 4'b1111;
  assign wdata_d  = size_i == 2'd0 ? {4{wdata_i[7:0]}} : size_i == 2'd1 ? {2{wdata_i[15:0]}} : wdata_i;
  assign busy     = state_q == REQ || state_q == RESP;
  assign complete = state_q == REQ ? bus.gnt && bus.rvalid : state_q == RESP && bus.rvalid;
  // A completion landing on the last allowed cycle beats the timeout.
  assign tmo      = busy && cnt_q == CW'(TIMEOUT_CYCLES - 1) && !complete;
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (valid_i ? (misalign ? DONE : REQ) : IDLE)
            : state_q == REQ  ? (complete || tmo ? DONE : bus.gnt ? RESP : REQ)
            : state_q == RESP ? (complete || tmo ? DONE : RESP)
            : IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= busy ? cnt_q + 1'b1 : '0;
      if (state_q == IDLE && valid_i) begin
        mis_q <= misalign;
        err_q <= 1'b0;
        if (!misalign) begin
          we_q    <= we_i;
          addr_q  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
          be_q    <= be_d;
          wdata_q <= wdata_d;
        end
      end
      if (tmo) err_q <= 1'b1;
      if (complete && !we_q) rdata_q <= bus.rdata;
    end
  end
  assign stall_o    = (state_q == IDLE && valid_i) || busy;
  assign done_o     = state_q == DONE;
  assign misalign_o = done_o && mis_q;
  assign err_o      = done_o && err_q;
  assign rdata_o    = rdata_q;
  assign bus.req    = state_q == REQ;
  assign bus.we     = we_q;
  assign bus.addr   = addr_q;
  assign bus.be     = be_q;
  assign bus.wdata  = wdata_q;
endmodule

// File: tb/tb_rv32im_dmem_ctrl.sv
// tb_rv32im_dmem_ctrl: vector table with a scoreboard of expected completions plus reset corner cases.
module tb_rv32im_dmem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, we = 1'b0;
  logic [1:0]  size = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall_o, done_o, misalign_o, err_o;
  logic [31:0] rdata_o;
  int          total = 0, bad = 0;
  logic [31:0] last_rd = '0;
  rv32im_dmem_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  rv32im_dmem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .we_i(we), .size_i(size), .addr_i(addr),
    .wdata_i(wdata), .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
    .misalign_o(misalign_o), .err_o(err_o), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic we; logic [1:0] size; logic [31:0] addr, wdata;
    int gd, rd; logic [31:0] bus_rd; logic [3:0] be; logic [31:0] bwd;
    logic mis, err; int lat, nreq;
  } vec_t;
  typedef struct { logic [31:0] rdata; logic mis, err; int lat; } exp_t;
  vec_t vecs[15];
  exp_t sb[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int cyc = 0, nreq = 0, nresp = 0;
    bit granted = 0, seen = 0, stall_ok = 1;
    @(negedge clk);
    chk($sformatf("idle_pulses[%0d]", idx), {done_o, misalign_o, err_o}, 0);
    valid = 1'b1; we = v.we; size = v.size; addr = v.addr; wdata = v.wdata;
    bus.rdata = v.bus_rd;
    e.rdata = (v.we || v.mis || v.err) ? last_rd : v.bus_rd;
    e.mis = v.mis; e.err = v.err; e.lat = v.lat;
    sb.push_back(e);
    last_rd = e.rdata;
    #1 chk($sformatf("stall_accept[%0d]", idx), stall_o, 1);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      valid = 1'b0; cyc++; bus.gnt = 1'b0; bus.rvalid = 1'b0;
      if (done_o) begin
        seen = 1;
        e = sb.pop_front();
        chk($sformatf("latency[%0d]", idx), cyc, e.lat);
        chk($sformatf("rdata[%0d]", idx), rdata_o, e.rdata);
        chk($sformatf("misalign[%0d]", idx), misalign_o, e.mis);
        chk($sformatf("err[%0d]", idx), err_o, e.err);
        chk($sformatf("stall_done[%0d]", idx), stall_o, 0);
        chk($sformatf("nreq[%0d]", idx), nreq, v.nreq);
      end else begin
        if (!stall_o) stall_ok = 0;
        if (bus.req) begin
          nreq++;
          if (nreq == 1 || nreq == v.gd + 1)
            chk($sformatf("bus_fields[%0d]", idx), {bus.addr[31:0]}, {v.addr[31:2], 2'b00});
          if (nreq == 1) begin
            chk($sformatf("bus_be[%0d]", idx), bus.be, v.be);
            chk($sformatf("bus_we[%0d]", idx), bus.we, v.we);
            chk($sformatf("bus_wdata[%0d]", idx), bus.wdata, v.bwd);
          end
          if (nreq == v.gd + 1) begin
            bus.gnt = 1'b1; granted = 1; bus.rvalid = v.rd == 0;
          end
        end else if (granted) begin
          nresp++;
          bus.rvalid = nresp == v.rd;
        end
      end
    end
    chk($sformatf("stall_hold[%0d]", idx), stall_ok, 1);
    if (!seen) chk($sformatf("done_seen[%0d]", idx), 0, 1);
  endtask
  initial begin
    vecs[0]  = '{1'b0, 2'd2, 32'h1000, 32'h0,        2,  1, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1'b0, 5,  3};
    vecs[1]  = '{1'b1, 2'd0, 32'h1003, 32'hAB,       1,  0, 32'hFFFFFFFF, 4'h8, 32'hABABABAB, 1'b0, 1'b0, 3,  2};
    vecs[2]  = '{1'b0, 2'd2, 32'h1002, 32'h0,        0,  0, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 1,  0};
    vecs[3]  = '{1'b0, 2'd1, 32'h1001, 32'h0,        0,  0, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 1,  0};
    vecs[4]  = '{1'b0, 2'd1, 32'h1002, 32'h0,        0,  2, 32'h5555AAAA, 4'hC, 32'h0,        1'b0, 1'b0, 4,  1};
    vecs[5]  = '{1'b0, 2'd2, 32'h2000, 32'h0,        0,  0, 32'h12345678, 4'hF, 32'h0,        1'b0, 1'b0, 2,  1};
    vecs[6]  = '{1'b1, 2'd1, 32'h2002, 32'h1234BEEF, 0,  1, 32'hFFFFFFFF, 4'hC, 32'hBEEFBEEF, 1'b0, 1'b0, 3,  1};
    vecs[7]  = '{1'b0, 2'd0, 32'h2001, 32'h0,        1,  1, 32'h00AB0000, 4'h2, 32'h0,        1'b0, 1'b0, 4,  2};
    vecs[8]  = '{1'b1, 2'd3, 32'h3000, 32'hCAFEF00D, 0,  0, 32'h11111111, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 2,  1};
    vecs[9]  = '{1'b1, 2'd3, 32'h3001, 32'h5,        0,  0, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 1,  0};
    vecs[10] = '{1'b0, 2'd2, 32'h4000, 32'h0,        99, 0, 32'h77777777, 4'hF, 32'h0,        1'b0, 1'b1, 17, 16};
    vecs[11] = '{1'b0, 2'd2, 32'h4004, 32'h0,        15, 0, 32'h88888888, 4'hF, 32'h0,        1'b0, 1'b0, 17, 16};
    vecs[12] = '{1'b0, 2'd2, 32'h4008, 32'h0,        14, 1, 32'h99999999, 4'hF, 32'h0,        1'b0, 1'b0, 17, 15};
    vecs[13] = '{1'b0, 2'd2, 32'h400C, 32'h0,        14, 2, 32'hAAAAAAAA, 4'hF, 32'h0,        1'b0, 1'b1, 17, 15};
    vecs[14] = '{1'b0, 2'd0, 32'h5003, 32'h0,        0,  1, 32'h0BADF00D, 4'h8, 32'h0,        1'b0, 1'b0, 3,  1};
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    #12;
    chk("reset_ctrl", {stall_o, done_o, misalign_o, err_o, bus.req, bus.we}, 0);
    chk("reset_rdata", rdata_o, 0);
    chk("reset_bus", {bus.addr ^ bus.wdata, 28'h0, bus.be}, 0);
    chk("reset_bus_addr", bus.addr, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);
    // Reset while the request is outstanding must drop it without a clock edge.
    @(negedge clk);
    valid = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h6000; bus.rdata = 32'h13579BDF;
    @(negedge clk); valid = 1'b0;
    chk("rst_req_pre", bus.req, 1);
    #2 rst = 1'b1;
    #1 chk("rst_req_drop", {bus.req, stall_o, done_o}, 0);
    chk("rst_req_rdata", rdata_o, 0);
    last_rd = '0;
    @(negedge clk); rst = 1'b0;
    // Reset during the response wait, then a stray response.
    @(negedge clk);
    valid = 1'b1; addr = 32'h6004;
    @(negedge clk); valid = 1'b0; bus.gnt = 1'b1;
    @(negedge clk); bus.gnt = 1'b0;
    chk("rst_resp_pre", {bus.req, stall_o}, 2'b01);
    #2 rst = 1'b1;
    #1 chk("rst_resp_drop", {bus.req, stall_o, done_o}, 0);
    @(negedge clk); rst = 1'b0; bus.rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stray_rvalid[%0d]", i), {done_o, stall_o, bus.req}, 0);
    end
    bus.rvalid = 1'b0;
    chk("stray_rdata", rdata_o, 0);
    run_vec(15, vecs[5]);
    run_vec(16, vecs[2]);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
